if_id_fetch_buffer: RTL and testbench

//  Sits between the IF stage PC logic and ID. Runs the instruction-memory request/response handshake.

---
 rtl/if_id_fetch_buffer_pkg.sv | 19 +
 rtl/if_id_fetch_buffer_if_id_reg.sv | 41 ++++
 rtl/if_id_fetch_buffer.sv | 127 ++++++++++++
 tb/tb_if_id_fetch_buffer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_fetch_buffer_pkg.sv
// rtl/if_id_fetch_buffer_pkg.sv - shared types for the IF/ID fetch buffer
package if_id_fetch_buffer_pkg;

  localparam int IFBUF_XLEN = 32;
  localparam logic [IFBUF_XLEN-1:0] IFBUF_NOP = 32'h00000013;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } ifbuf_state_t;

  typedef struct packed {
    logic [IFBUF_XLEN-1:0] pc;
    logic [IFBUF_XLEN-1:0] instr;
    logic                  valid;
  } if_id_t;

endpackage

// File: rtl/if_id_fetch_buffer_if_id_reg.sv
// rtl/if_id_fetch_buffer_if_id_reg.sv - IF/ID pipeline register with load and clear
module if_id_reg
  import if_id_fetch_buffer_pkg::*;
#(
  parameter logic [IFBUF_XLEN-1:0] NOP_INSTR = IFBUF_NOP
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   clear_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t reg_q;
  if_id_t reg_d;

  // Clear wins over load; pc is kept on clear since it is meaningless without valid.
  always_comb begin
    reg_d = reg_q;
    if (clear_i) begin
      reg_d.valid = 1'b0;
      reg_d.instr = NOP_INSTR;
    end else if (load_i) begin
      reg_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_q.pc    <= '0;
      reg_q.instr <= NOP_INSTR;
      reg_q.valid <= 1'b0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign q_o = reg_q;

endmodule

// File: rtl/if_id_fetch_buffer.sv
// rtl/if_id_fetch_buffer.sv - imem handshake, IF/ID register, skid buffer and redirect squash
module if_id_fetch_buffer
  import if_id_fetch_buffer_pkg::*;
#(
  parameter int              XLEN      = IFBUF_XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = IFBUF_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] IF_pc_i,
  output logic            pc_load_o,
  output logic            imem_read_o,
  output logic [XLEN-1:0] imem_address_o,
  input  logic            imem_resp_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] IF_ID_pc_o,
  output logic [XLEN-1:0] IF_ID_instr_o,
  output logic            IF_ID_valid_o
);

  ifbuf_state_t    state_q, state_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [XLEN-1:0] buf_instr_q, buf_instr_d;

  logic   ifid_load;
  logic   ifid_clear;
  if_id_t ifid_d;
  if_id_t ifid_q;

  always_comb begin
    state_d        = state_q;
    req_addr_d     = req_addr_q;
    buf_pc_d       = buf_pc_q;
    buf_instr_d    = buf_instr_q;
    pc_load_o      = 1'b0;
    imem_read_o    = 1'b0;
    imem_address_o = req_addr_q;
    ifid_load      = 1'b0;
    ifid_clear     = 1'b0;
    ifid_d.pc      = IF_pc_i;
    ifid_d.instr   = imem_rdata_i;
    ifid_d.valid   = 1'b1;

    case (state_q)
      FETCH: begin
        imem_read_o    = 1'b1;
        imem_address_o = IF_pc_i;
        req_addr_d     = IF_pc_i;
        if (flush_i) begin
          pc_load_o  = 1'b1;
          ifid_clear = 1'b1;
          // A request still in flight must be drained before the redirected fetch issues.
          if (!imem_resp_i) state_d = SQUASH;
        end else if (imem_resp_i && !stall_i) begin
          ifid_load = 1'b1;
          pc_load_o = 1'b1;
        end else if (imem_resp_i) begin
          buf_pc_d    = IF_pc_i;
          buf_instr_d = imem_rdata_i;
          state_d     = HOLD;
        end else if (!stall_i) begin
          ifid_clear = 1'b1;
        end
      end

      HOLD: begin
        if (flush_i) begin
          ifid_clear = 1'b1;
          pc_load_o  = 1'b1;
          state_d    = FETCH;
        end else if (!stall_i) begin
          ifid_d.pc    = buf_pc_q;
          ifid_d.instr = buf_instr_q;
          ifid_load    = 1'b1;
          pc_load_o    = 1'b1;
          state_d      = FETCH;
        end
      end

      SQUASH: begin
        imem_read_o    = 1'b1;
        imem_address_o = req_addr_q;
        pc_load_o      = flush_i;
        ifid_clear     = 1'b1;
        if (imem_resp_i) state_d = FETCH;
      end

      default: begin
        state_d    = FETCH;
        ifid_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      req_addr_q  <= '0;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ifid_load),
    .clear_i (ifid_clear),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign IF_ID_pc_o    = ifid_q.pc;
  assign IF_ID_instr_o = ifid_q.instr;
  assign IF_ID_valid_o = ifid_q.valid;

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// tb/tb_if_id_fetch_buffer.sv - directed self-checking bench for if_id_fetch_buffer
module tb_if_id_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_pc_i;
  logic        pc_load_o;
  logic        imem_read_o;
  logic [31:0] imem_address_o;
  logic        imem_resp_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] IF_ID_pc_o;
  logic [31:0] IF_ID_instr_o;
  logic        IF_ID_valid_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  if_id_fetch_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .IF_pc_i        (IF_pc_i),
    .pc_load_o      (pc_load_o),
    .imem_read_o    (imem_read_o),
    .imem_address_o (imem_address_o),
    .imem_resp_i    (imem_resp_i),
    .imem_rdata_i   (imem_rdata_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .IF_ID_pc_o     (IF_ID_pc_o),
    .IF_ID_instr_o  (IF_ID_instr_o),
    .IF_ID_valid_o  (IF_ID_valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, then let combinational outputs settle.
  task automatic drive(input logic [31:0] pc, input logic resp, input logic [31:0] rdata,
                       input logic stall, input logic flush);
    @(negedge clk);
    IF_pc_i      = pc;
    imem_resp_i  = resp;
    imem_rdata_i = rdata;
    stall_i      = stall;
    flush_i      = flush;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic valid);
    chk({tag, "_valid"}, {31'd0, IF_ID_valid_o}, {31'd0, valid});
    chk({tag, "_instr"}, IF_ID_instr_o, instr);
    if (valid) chk({tag, "_pc"}, IF_ID_pc_o, pc);
  endtask

  initial begin
    rst = 1'b0;
    IF_pc_i = '0; imem_resp_i = 1'b0; imem_rdata_i = '0; stall_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_ifid("reset", 32'h0, NOP, 1'b0);
    chk("reset_pc", IF_ID_pc_o, 32'h0);
    chk("reset_read", {31'd0, imem_read_o}, 32'd1);
    chk("reset_addr", imem_address_o, 32'h0);
    chk("reset_pcload", {31'd0, pc_load_o}, 32'd0);

    // Reset asserted mid-run clears IF/ID immediately
    drive(32'h60, 1'b1, 32'hA1A1A1A1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_ifid("pre_rst", 32'h60, 32'hA1A1A1A1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_ifid("async_rst", 32'h0, NOP, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    drive(32'h60, 1'b1, 32'h00100093, 1'b0, 1'b0);
    chk("b2b0_pcload", {31'd0, pc_load_o}, 32'd1);
    tick();
    chk_ifid("b2b0", 32'h60, 32'h00100093, 1'b1);
    drive(32'h64, 1'b1, 32'h00200113, 1'b0, 1'b0);
    chk("b2b1_addr", imem_address_o, 32'h64);
    tick();
    chk_ifid("b2b1", 32'h64, 32'h00200113, 1'b1);

    // Three-cycle latency produces three bubbles
    for (int i = 0; i < 3; i++) begin
      drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("lat_addr", imem_address_o, 32'h100);
      chk("lat_pcload", {31'd0, pc_load_o}, 32'd0);
      tick();
      chk_ifid("lat_bubble", 32'h0, NOP, 1'b0);
    end
    drive(32'h100, 1'b1, 32'h11111113, 1'b0, 1'b0);
    chk("lat_pcload_pulse", {31'd0, pc_load_o}, 32'd1);
    tick();
    chk_ifid("lat_done", 32'h100, 32'h11111113, 1'b1);

    // Response while stalled goes to the skid buffer
    drive(32'h104, 1'b1, 32'h00A00093, 1'b1, 1'b0);
    chk("skid_pcload", {31'd0, pc_load_o}, 32'd0);
    tick();
    chk_ifid("skid_hold0", 32'h100, 32'h11111113, 1'b1);
    drive(32'h104, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("skid_read", {31'd0, imem_read_o}, 32'd0);
    chk("skid_pcload1", {31'd0, pc_load_o}, 32'd0);
    tick();
    chk_ifid("skid_hold1", 32'h100, 32'h11111113, 1'b1);
    drive(32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("skid_release_pcload", {31'd0, pc_load_o}, 32'd1);
    tick();
    chk_ifid("skid_release", 32'h104, 32'h00A00093, 1'b1);

    // Redirect with a request outstanding: squash the late response
    drive(32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("sq_req_addr", imem_address_o, 32'h200);
    tick();
    drive(32'h200, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("sq_flush_pcload", {31'd0, pc_load_o}, 32'd1);
    tick();
    chk_ifid("sq_flush", 32'h0, NOP, 1'b0);
    drive(32'h400, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("sq_hold_addr", imem_address_o, 32'h200);
    chk("sq_read", {31'd0, imem_read_o}, 32'd1);
    chk("sq_pcload", {31'd0, pc_load_o}, 32'd0);
    tick();
    drive(32'h400, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("sq_late_addr", imem_address_o, 32'h200);
    tick();
    chk_ifid("sq_discard", 32'h0, NOP, 1'b0);
    drive(32'h400, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("sq_new_addr", imem_address_o, 32'h400);
    tick();
    drive(32'h400, 1'b1, 32'h22222213, 1'b0, 1'b0);
    tick();
    chk_ifid("sq_new", 32'h400, 32'h22222213, 1'b1);

    // Flush and response in the same cycle: response dropped, stay in FETCH
    drive(32'h404, 1'b1, 32'h33333313, 1'b0, 1'b1);
    chk("fr_pcload", {31'd0, pc_load_o}, 32'd1);
    tick();
    chk_ifid("fr_drop", 32'h0, NOP, 1'b0);
    drive(32'h500, 1'b1, 32'h44444413, 1'b0, 1'b0);
    chk("fr_fetch_addr", imem_address_o, 32'h500);
    tick();
    chk_ifid("fr_next", 32'h500, 32'h44444413, 1'b1);

    // Flush while holding a buffered response
    drive(32'h504, 1'b1, 32'h55555513, 1'b1, 1'b0);
    tick();
    drive(32'h504, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("hf_pcload", {31'd0, pc_load_o}, 32'd1);
    chk("hf_read", {31'd0, imem_read_o}, 32'd0);
    tick();
    chk_ifid("hf_clear", 32'h0, NOP, 1'b0);
    drive(32'h600, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("hf_fetch_addr", imem_address_o, 32'h600);
    chk("hf_fetch_read", {31'd0, imem_read_o}, 32'd1);
    drive(32'h600, 1'b1, 32'h66666613, 1'b0, 1'b0);
    tick();
    chk_ifid("hf_next", 32'h600, 32'h66666613, 1'b1);

    // Flush beats stall in FETCH
    drive(32'h604, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("fs_pcload", {31'd0, pc_load_o}, 32'd1);
    tick();
    chk_ifid("fs_clear", 32'h0, NOP, 1'b0);
    drive(32'h800, 1'b1, 32'h77777713, 1'b0, 1'b1);
    chk("fs_sq_addr", imem_address_o, 32'h604);
    chk("fs_sq_pcload", {31'd0, pc_load_o}, 32'd1);
    tick();
    chk_ifid("fs_sq_discard", 32'h0, NOP, 1'b0);

    // Address passes through at the top of the address space
    drive(32'hFFFFFFFC, 1'b1, 32'h88888813, 1'b0, 1'b0);
    chk("wrap_addr", imem_address_o, 32'hFFFFFFFC);
    tick();
    chk_ifid("wrap", 32'hFFFFFFFC, 32'h88888813, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
